// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for memory_arbiter: FSM state encoding, default widths
// and the round-robin pointer wrap function.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    function automatic int next_rr(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after rr_ptr,
// wrapping modulo NUM_REQ. Outputs one-hot grant, binary index and an any flag.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = int'(i_rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = next_rr(w_j, NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = PTR_W'(w_j);
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory_core among NUM_REQ requesters (ARB->ACCESS->RESP).
// Optional per-requester grant counters when MEM_ARB_STATS_EN is defined.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           ce_mem,
    output logic                           we_mem,
    output logic [ADDR_W-1:0]              addr_mem,
    output logic [DATA_W-1:0]              datai_mem,
    input  logic [DATA_W-1:0]              datao_mem
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][CNT_W-1:0]  grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1) begin : g_bad_param
        $error("memory_arbiter: parameter out of range");
    end

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;
    logic               w_accept;
    logic               r_ce;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // req_ready is also gated by reset so nothing is offered while the block is held in reset
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_rdata   = '0;
        case (r_state)
            ARB: begin
                if (w_any && reset) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[r_win] = 1'b1;
                rsp_rdata        = r_we ? '0 : datao_mem;
                w_state_nxt      = ARB;
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= PTR_W'(NUM_REQ - 1);
            r_win    <= '0;
            r_ce     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_ce <= w_accept;
            if (w_accept) begin
                r_rr_ptr <= w_idx;
                r_win    <= w_idx;
                r_we     <= req_we[w_idx];
                r_addr   <= req_addr[w_idx];
                r_wdata  <= req_wdata[w_idx];
            end
        end
    end

    assign ce_mem    = r_ce;
    assign we_mem    = r_we;
    assign addr_mem  = r_addr;
    assign datai_mem = r_wdata;

`ifdef MEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] r_grant_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept && w_grant[i]) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule
